// File: rtl/kbd_event_fifo_pkg.sv
// Shared definitions for the keyboard event FIFO.
// An event is 10 bits: {extend, make, code[7:0]}.
package kbd_pkg;

    localparam int KBD_EVENT_W = 10;
    localparam int EV_CODE_LSB = 0;
    localparam int EV_MAKE_BIT = 8;
    localparam int EV_EXT_BIT  = 9;

    typedef struct packed {
        logic       extend;
        logic       make;
        logic [7:0] code;
    } kbd_event_t;

endpackage

// File: rtl/kbd_event_fifo_if.sv
// Keyboard event interface between the key source / HC800 I/O logic (master)
// and the event FIFO (slave).
//
// Handshake: key_strobe is a one-cycle qualifier for key_code/key_pressed/
// key_extended and is never back-pressured. ev_valid means the ev_* head
// fields are meaningful. A pop in a cycle where ev_valid=1 consumes the head
// at the next rising edge. A pop while ev_valid=0 is ignored.
interface kbd_event_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  key_strobe;
    logic [7:0]            key_code;
    logic                  key_pressed;
    logic                  key_extended;
    logic                  pop;
    logic                  ovf_clear;
    logic                  ev_valid;
    logic [7:0]            ev_code;
    logic                  ev_make;
    logic                  ev_extend;
    logic [DEPTH_LOG2:0]   ev_count;
    logic                  overflow;

    modport master (
        output key_strobe, key_code, key_pressed, key_extended, pop, ovf_clear,
        input  ev_valid, ev_code, ev_make, ev_extend, ev_count, overflow
    );

    modport slave (
        input  key_strobe, key_code, key_pressed, key_extended, pop, ovf_clear,
        output ev_valid, ev_code, ev_make, ev_extend, ev_count, overflow
    );
endinterface

// File: rtl/kbd_event_ring.sv
// Generic first-word-fall-through register FIFO of 2^DEPTH_LOG2 event entries.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   push, din  - write request and data (accepted when not full, or when full
//                and a pop happens in the same cycle)
//   pop        - consume head; ignored when empty
//   dout       - head entry, combinational read, zero when empty
//   count      - occupancy 0..2^DEPTH_LOG2
//   full/empty - occupancy flags
module kbd_event_ring
    import kbd_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [KBD_EVENT_W-1:0] din,
    input  logic                   pop,
    output logic [KBD_EVENT_W-1:0] dout,
    output logic [DEPTH_LOG2:0]    count,
    output logic                   full,
    output logic                   empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

    logic [KBD_EVENT_W-1:0] mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]  wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0]  rptr_q, rptr_d;
    logic [DEPTH_LOG2:0]    count_q, count_d;
    logic                   do_push;
    logic                   do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_CNT);

    // A pop on a full ring frees the slot the simultaneous push lands in.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed while count > 0.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din;
    end

    assign dout  = empty ? '0 : mem_q[rptr_q];
    assign count = count_q;
endmodule

// File: rtl/kbd_event_fifo.sv
// Keyboard event buffer between user_io key events and the HC800 keyboard
// port. Holds a 512-bit held-key bitmap indexed by {extended, code} to
// optionally drop host auto-repeat makes, and a sticky overflow flag for
// events lost while the ring is full.
// Ports:
//   bus_clk, bus_reset - bus clock, synchronous active-high reset
//   kbd (slave)        - key strobe inputs, pop/ovf_clear, FWFT head outputs,
//                        occupancy and overflow
module kbd_event_fifo
    import kbd_pkg::*;
#(
    parameter int DEPTH_LOG2    = 4,
    parameter int REPEAT_FILTER = 1
) (
    input  logic           bus_clk,
    input  logic           bus_reset,
    kbd_event_fifo_if.slave kbd
);
    logic [511:0]           held_q, held_d;
    logic                   overflow_q, overflow_d;
    logic [8:0]             key_idx;
    logic                   filtered;
    logic                   accept;
    kbd_event_t             ev_in;
    logic [KBD_EVENT_W-1:0] ev_out;
    logic                   ring_full;
    logic                   ring_empty;

    assign key_idx  = {kbd.key_extended, kbd.key_code};
    assign filtered = (REPEAT_FILTER != 0) && kbd.key_pressed && held_q[key_idx];
    assign accept   = kbd.key_strobe && !filtered;

    assign ev_in.extend = kbd.key_extended;
    assign ev_in.make   = kbd.key_pressed;
    assign ev_in.code   = kbd.key_code;

    // Make sets, break clears; a filtered make finds the bit already set.
    // The bitmap tracks key state even when the push is dropped as full.
    always_comb begin
        held_d = held_q;
        if (kbd.key_strobe) held_d[key_idx] = kbd.key_pressed;
    end

    // A drop only happens when full with no pop to free a slot; a drop wins
    // over a same-cycle clear.
    always_comb begin
        overflow_d = overflow_q;
        if (accept && ring_full && !kbd.pop) overflow_d = 1'b1;
        else if (kbd.ovf_clear)              overflow_d = 1'b0;
    end

    always_ff @(posedge bus_clk) begin
        if (bus_reset) begin
            held_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            held_q     <= held_d;
            overflow_q <= overflow_d;
        end
    end

    kbd_event_ring #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ring (
        .clk   (bus_clk),
        .rst   (bus_reset),
        .push  (accept),
        .din   (ev_in),
        .pop   (kbd.pop),
        .dout  (ev_out),
        .count (kbd.ev_count),
        .full  (ring_full),
        .empty (ring_empty)
    );

    assign kbd.ev_valid  = !ring_empty;
    assign kbd.ev_code   = ev_out[EV_CODE_LSB +: 8];
    assign kbd.ev_make   = ev_out[EV_MAKE_BIT];
    assign kbd.ev_extend = ev_out[EV_EXT_BIT];
    assign kbd.overflow  = overflow_q;
endmodule

// File: tb/tb_kbd_event_fifo.sv
// Directed bench for kbd_event_fifo. Inputs change on the falling edge and
// outputs are sampled on the falling edge after the capturing rising edge.
module tb_kbd_event_fifo;

    logic clk;
    logic bus_reset;
    int   checks;
    int   errors;
    logic [9:0] exp_q[$];

    kbd_event_fifo_if #(.DEPTH_LOG2(4)) kif ();

    kbd_event_fifo #(
        .DEPTH_LOG2   (4),
        .REPEAT_FILTER(1)
    ) dut (
        .bus_clk  (clk),
        .bus_reset(bus_reset),
        .kbd      (kif.slave)
    );

    // Observation vector: {valid, extend, make, code[7:0], count[4:0], overflow}
    logic [16:0] obs;
    assign obs = {kif.ev_valid, kif.ev_extend, kif.ev_make, kif.ev_code,
                  kif.ev_count, kif.overflow};

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic idle_inputs();
        kif.key_strobe   = 1'b0;
        kif.key_code     = 8'h00;
        kif.key_pressed  = 1'b0;
        kif.key_extended = 1'b0;
        kif.pop          = 1'b0;
        kif.ovf_clear    = 1'b0;
    endtask

    task automatic drive(input logic stb, input logic [7:0] code, input logic mk,
                         input logic ext, input logic pp, input logic clr);
        @(negedge clk);
        kif.key_strobe   = stb;
        kif.key_code     = code;
        kif.key_pressed  = mk;
        kif.key_extended = ext;
        kif.pop          = pp;
        kif.ovf_clear    = clr;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        bus_reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus_reset = 1'b0;
    endtask

    // Scenarios
    task automatic test_reset();
        apply_reset();
        checks++;
        if (obs !== 17'd0) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", obs, 17'd0);
        end
    endtask

    task automatic test_basic();
        apply_reset();
        drive(1'b1, 8'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b1, 8'h1C, 5'd1, 1'b0}) begin
            errors++;
            $display("FAIL basic_push got=%h exp=%h", obs, {1'b1, 1'b0, 1'b1, 8'h1C, 5'd1, 1'b0});
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (obs !== 17'd0) begin
            errors++;
            $display("FAIL basic_pop got=%h exp=%h", obs, 17'd0);
        end
        // Pop when empty is a no-op.
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (obs !== 17'd0) begin
            errors++;
            $display("FAIL pop_empty got=%h exp=%h", obs, 17'd0);
        end
    endtask

    task automatic test_repeat_filter();
        logic [9:0] exp_heads [3];
        exp_heads[0] = {1'b0, 1'b1, 8'h1C};
        exp_heads[1] = {1'b0, 1'b0, 8'h1C};
        exp_heads[2] = {1'b0, 1'b1, 8'h1C};
        apply_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 8'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (kif.ev_count !== 5'd2) begin
            errors++;
            $display("FAIL repeat_count got=%0d exp=2", kif.ev_count);
        end
        drive(1'b1, 8'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (kif.ev_count !== 5'd3) begin
            errors++;
            $display("FAIL repeat_remake_count got=%0d exp=3", kif.ev_count);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({kif.ev_extend, kif.ev_make, kif.ev_code} !== exp_heads[i]) begin
                errors++;
                $display("FAIL repeat_order[%0d] got=%h exp=%h", i,
                         {kif.ev_extend, kif.ev_make, kif.ev_code}, exp_heads[i]);
            end
            drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        checks++;
        if (kif.ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL repeat_drained got=%b exp=0", kif.ev_valid);
        end
    endtask

    task automatic test_extended();
        apply_reset();
        drive(1'b1, 8'h75, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8'h75, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== {1'b1, 1'b1, 1'b1, 8'h75, 5'd2, 1'b0}) begin
            errors++;
            $display("FAIL ext_first got=%h exp=%h", obs, {1'b1, 1'b1, 1'b1, 8'h75, 5'd2, 1'b0});
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b1, 8'h75, 5'd1, 1'b0}) begin
            errors++;
            $display("FAIL ext_second got=%h exp=%h", obs, {1'b1, 1'b0, 1'b1, 8'h75, 5'd1, 1'b0});
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 16; i++) drive(1'b1, 8'h10 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({kif.ev_count, kif.overflow} !== {5'd16, 1'b0}) begin
            errors++;
            $display("FAIL ovf_full got=%0d/%b exp=16/0", kif.ev_count, kif.overflow);
        end
        drive(1'b1, 8'h50, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({kif.ev_count, kif.overflow} !== {5'd16, 1'b1}) begin
            errors++;
            $display("FAIL ovf_set got=%0d/%b exp=16/1", kif.ev_count, kif.overflow);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (kif.overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got=%b exp=0", kif.overflow);
        end
        drive(1'b1, 8'h51, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (kif.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_beats_clear got=%b exp=1", kif.overflow);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({kif.ev_valid, kif.ev_code} !== {1'b1, 8'h10 + 8'(i)}) begin
                errors++;
                $display("FAIL ovf_drain[%0d] got=%h exp=%h", i,
                         {kif.ev_valid, kif.ev_code}, {1'b1, 8'h10 + 8'(i)});
            end
            drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        checks++;
        if ({kif.ev_valid, kif.ev_count} !== 6'd0) begin
            errors++;
            $display("FAIL ovf_empty got=%b/%0d exp=0/0", kif.ev_valid, kif.ev_count);
        end
    endtask

    task automatic test_full_push_pop();
        apply_reset();
        for (int i = 0; i < 16; i++) drive(1'b1, 8'h20 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h60, 1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({kif.ev_count, kif.overflow} !== {5'd16, 1'b0}) begin
            errors++;
            $display("FAIL full_pp got=%0d/%b exp=16/0", kif.ev_count, kif.overflow);
        end
        for (int i = 0; i < 16; i++) begin
            logic [7:0] exp_code;
            exp_code = (i == 15) ? 8'h60 : 8'h21 + 8'(i);
            checks++;
            if ({kif.ev_valid, kif.ev_code} !== {1'b1, exp_code}) begin
                errors++;
                $display("FAIL full_pp_drain[%0d] got=%h exp=%h", i,
                         {kif.ev_valid, kif.ev_code}, {1'b1, exp_code});
            end
            drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        drive(1'b1, 8'h61, 1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b1, 8'h61, 5'd1, 1'b0}) begin
            errors++;
            $display("FAIL empty_pp got=%h exp=%h", obs, {1'b1, 1'b0, 1'b1, 8'h61, 5'd1, 1'b0});
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_wrap();
        logic [7:0] code;
        logic       ext;
        apply_reset();
        exp_q.delete();
        // Break events are never filtered, so every strobe is a push.
        for (int i = 0; i < 3; i++) begin
            code = 8'($urandom_range(0, 255));
            ext  = 1'($urandom_range(0, 1));
            drive(1'b1, code, 1'b0, ext, 1'b0, 1'b0);
            exp_q.push_back({ext, 1'b0, code});
        end
        for (int i = 0; i < 40; i++) begin
            checks++;
            if ({kif.ev_extend, kif.ev_make, kif.ev_code} !== exp_q[0]) begin
                errors++;
                $display("FAIL wrap_head[%0d] got=%h exp=%h", i,
                         {kif.ev_extend, kif.ev_make, kif.ev_code}, exp_q[0]);
            end
            code = 8'($urandom_range(0, 255));
            ext  = 1'($urandom_range(0, 1));
            drive(1'b1, code, 1'b0, ext, 1'b1, 1'b0);
            void'(exp_q.pop_front());
            exp_q.push_back({ext, 1'b0, code});
        end
        checks++;
        if (kif.ev_count !== 5'd3) begin
            errors++;
            $display("FAIL wrap_count got=%0d exp=3", kif.ev_count);
        end
        while (exp_q.size() > 0) begin
            checks++;
            if ({kif.ev_valid, kif.ev_extend, kif.ev_make, kif.ev_code} !== {1'b1, exp_q[0]}) begin
                errors++;
                $display("FAIL wrap_drain got=%h exp=%h",
                         {kif.ev_valid, kif.ev_extend, kif.ev_make, kif.ev_code}, {1'b1, exp_q[0]});
            end
            drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 8'h33 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (kif.ev_count !== 5'd5) begin
            errors++;
            $display("FAIL rst_mid_fill got=%0d exp=5", kif.ev_count);
        end
        @(negedge clk);
        bus_reset        = 1'b1;
        kif.key_strobe   = 1'b1;
        kif.key_code     = 8'h38;
        kif.key_pressed  = 1'b1;
        kif.pop          = 1'b1;
        @(negedge clk);
        bus_reset = 1'b0;
        idle_inputs();
        checks++;
        if (obs !== 17'd0) begin
            errors++;
            $display("FAIL rst_mid_state got=%h exp=%h", obs, 17'd0);
        end
        drive(1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b1, 8'h33, 5'd1, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_remake got=%h exp=%h", obs, {1'b1, 1'b0, 1'b1, 8'h33, 5'd1, 1'b0});
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        bus_reset = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_repeat_filter();
        test_extended();
        test_overflow();
        test_full_push_pop();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
